// File: rtl/lpc_analysis_filt.sv
// LPC analysis (prediction-error) filter: e[n] = x[n] - sum A_k*x[n-k], k=1..10, one MAC per cycle.
// Optional output saturation is enabled by defining LPC_ANALYSIS_SAT_EN.
module lpc_analysis_filt #(
   parameter int ACC_W = 36,
   parameter int FRAC  = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               v,
   input  logic signed [15:0] x,
   input  logic signed [15:0] A0,
   input  logic signed [15:0] A1,
   input  logic signed [15:0] A2,
   input  logic signed [15:0] A3,
   input  logic signed [15:0] A4,
   input  logic signed [15:0] A5,
   input  logic signed [15:0] A6,
   input  logic signed [15:0] A7,
   input  logic signed [15:0] A8,
   input  logic signed [15:0] A9,
   input  logic signed [15:0] A10,
   output logic               rdy,
   output logic signed [15:0] y,
   output logic               vout
);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

   state_t                   r_state;
   state_t                   w_nextState;
   logic                     w_accept;
   logic [3:0]               r_k;
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [15:0]       r_x0;
   logic signed [15:0]       r_hist [1:10];
   logic signed [15:0]       r_coef [1:10];
   logic signed [15:0]       r_y;
   logic                     r_vout;
   logic signed [15:0]       w_coefK;
   logic signed [15:0]       w_histK;
   logic signed [31:0]       w_prod;
   logic signed [15:0]       w_result;
   logic                     w_unusedA0;

   // A0 exists only for port parity with the synthesis filter
   assign w_unusedA0 = ^A0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      rdy         = 1'b0;
      case (r_state)
         S_IDLE: begin
            rdy = 1'b1;
            if (v) begin
               w_accept    = 1'b1;
               w_nextState = S_MAC;
            end
         end
         S_MAC:   if (r_k == 4'd10) w_nextState = S_DONE;
         S_DONE:  w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   always_comb begin
      w_coefK = '0;
      w_histK = '0;
      for (int i = 1; i <= 10; i++) begin
         if (r_k == 4'(i)) begin
            w_coefK = r_coef[i];
            w_histK = r_hist[i];
         end
      end
   end

   assign w_prod = 32'(w_coefK) * 32'(w_histK);

`ifdef LPC_ANALYSIS_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32'sd32767);
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32'sd32768);
   logic signed [ACC_W-1:0] w_shift;
   assign w_shift = r_acc >>> FRAC;
   always_comb begin
      if (w_shift > SAT_HI)      w_result = 16'sh7FFF;
      else if (w_shift < SAT_LO) w_result = 16'sh8000;
      else                       w_result = w_shift[15:0];
   end
`else
   assign w_result = r_acc[FRAC+15:FRAC];
`endif

   // Coefficients are banked on accept so upstream may update them mid-computation
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_k    <= '0;
         r_acc  <= '0;
         r_x0   <= '0;
         r_y    <= '0;
         r_vout <= 1'b0;
         for (int i = 1; i <= 10; i++) begin
            r_hist[i] <= '0;
            r_coef[i] <= '0;
         end
      end else begin
         r_vout <= (r_state == S_DONE);
         if (w_accept) begin
            r_x0      <= x;
            r_acc     <= ACC_W'(x) <<< FRAC;
            r_k       <= 4'd1;
            r_coef[1] <= A1;
            r_coef[2] <= A2;
            r_coef[3] <= A3;
            r_coef[4] <= A4;
            r_coef[5] <= A5;
            r_coef[6] <= A6;
            r_coef[7] <= A7;
            r_coef[8] <= A8;
            r_coef[9] <= A9;
            r_coef[10] <= A10;
         end else if (r_state == S_MAC) begin
            r_acc <= r_acc - ACC_W'(w_prod);
            r_k   <= r_k + 4'd1;
         end else if (r_state == S_DONE) begin
            r_y <= w_result;
            for (int i = 10; i >= 2; i--) r_hist[i] <= r_hist[i-1];
            r_hist[1] <= r_x0;
         end
      end
   end

   assign y    = r_y;
   assign vout = r_vout;

endmodule

// File: tb/tb_lpc_analysis_filt.sv
// Directed self-checking bench for lpc_analysis_filt; expected residuals are hand-computed.
// Overflow expectation follows LPC_ANALYSIS_SAT_EN.
module tb_lpc_analysis_filt;

   logic               clk = 1'b0;
   logic               rst;
   logic               v;
   logic signed [15:0] x;
   logic signed [15:0] A [0:10];
   logic               rdy;
   logic signed [15:0] y;
   logic               vout;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   lpc_analysis_filt dut (
      .clk(clk), .rst(rst), .v(v), .x(x),
      .A0(A[0]), .A1(A[1]), .A2(A[2]), .A3(A[3]), .A4(A[4]), .A5(A[5]),
      .A6(A[6]), .A7(A[7]), .A8(A[8]), .A9(A[9]), .A10(A[10]),
      .rdy(rdy), .y(y), .vout(vout)
   );

   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Sends one sample, watches the 11-cycle latency window and checks the residual
   task automatic applyStimulus(input string tag, input logic signed [15:0] xs,
                                input logic signed [15:0] expY, input bit dropMid,
                                input bit changeCoef);
      logic signed [15:0] saved [1:10];
      bit early;
      early = 1'b0;
      for (int i = 1; i <= 10; i++) saved[i] = A[i];
      @(negedge clk);
      checkOutput({tag, "_rdy_before"}, rdy, 1);
      v = 1'b1;
      x = xs;
      @(posedge clk);
      #1;
      v = 1'b0;
      x = 16'($urandom);
      checkOutput({tag, "_rdy_busy"}, rdy, 0);
      for (int e = 1; e <= 10; e++) begin
         if (changeCoef && e == 3)
            for (int i = 1; i <= 10; i++) A[i] = 16'($urandom);
         if (dropMid && e == 5) begin
            v = 1'b1;
            x = 16'sd500;
         end
         @(posedge clk);
         #1;
         if (dropMid && e == 5) begin
            v = 1'b0;
            checkOutput({tag, "_rdy_at_drop"}, rdy, 0);
         end
         if (vout) early = 1'b1;
      end
      @(posedge clk);
      #1;
      checkOutput({tag, "_no_early_vout"}, early, 0);
      checkOutput({tag, "_vout"}, vout, 1);
      checkOutput({tag, "_y"}, y, expY);
      checkOutput({tag, "_rdy_after"}, rdy, 1);
      for (int i = 1; i <= 10; i++) A[i] = saved[i];
      @(posedge clk);
      #1;
      checkOutput({tag, "_vout_one_cycle"}, vout, 0);
      checkOutput({tag, "_y_hold"}, y, expY);
   endtask

   initial begin
      bit sawVout;
      logic signed [15:0] expOvf;
      rst = 1'b0;
      v = 1'b0;
      x = '0;
      for (int i = 0; i <= 10; i++) A[i] = '0;
      A[0] = 16'sh1234;

      #12;
      checkOutput("reset_y", y, 0);
      checkOutput("reset_vout", vout, 0);
      checkOutput("reset_rdy", rdy, 1);
      @(negedge clk);
      rst = 1'b1;
      sawVout = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (vout) sawVout = 1'b1;
      end
      checkOutput("idle_no_vout", sawVout, 0);

      $display("[TB] impulse response, A1=0.5");
      A[1] = 16'sd16384;
      applyStimulus("imp0", 16'sd16384, 16'sd16384, 1'b0, 1'b0);
      applyStimulus("imp1", 16'sd0, -16'sd8192, 1'b0, 1'b1);
      applyStimulus("imp2", 16'sd0, 16'sd0, 1'b0, 1'b0);

      $display("[TB] truncation toward minus infinity");
      applyStimulus("trunc0", 16'sd1, 16'sd1, 1'b0, 1'b0);
      applyStimulus("trunc1", 16'sd0, -16'sd1, 1'b0, 1'b0);

      $display("[TB] constant input, A1=32767");
      A[1] = 16'sd32767;
      applyStimulus("const0", 16'sd1000, 16'sd1000, 1'b0, 1'b0);
      applyStimulus("const1", 16'sd1000, 16'sd0, 1'b0, 1'b0);
      applyStimulus("const2", 16'sd1000, 16'sd0, 1'b0, 1'b0);

      $display("[TB] dropped sample while busy");
      applyStimulus("drop0", 16'sd2000, 16'sd1000, 1'b1, 1'b0);
      applyStimulus("drop1", 16'sd3000, 16'sd1000, 1'b0, 1'b0);

      $display("[TB] overflow");
      applyStimulus("ovf_pre", 16'sd0, -16'sd3000, 1'b0, 1'b0);
      applyStimulus("ovf0", -16'sd32768, -16'sd32768, 1'b0, 1'b0);
`ifdef LPC_ANALYSIS_SAT_EN
      expOvf = 16'sd32767;
`else
      expOvf = -16'sd2;
`endif
      applyStimulus("ovf1", 16'sd32767, expOvf, 1'b0, 1'b0);

      $display("[TB] reset during MAC");
      A[1] = 16'sd16384;
      @(negedge clk);
      v = 1'b1;
      x = 16'sd12345;
      @(posedge clk);
      #1;
      v = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("midrst_rdy", rdy, 1);
      checkOutput("midrst_vout", vout, 0);
      checkOutput("midrst_y", y, 0);
      @(negedge clk);
      rst = 1'b1;
      sawVout = 1'b0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (vout) sawVout = 1'b1;
      end
      checkOutput("midrst_no_vout", sawVout, 0);
      applyStimulus("post_rst0", 16'sd16384, 16'sd16384, 1'b0, 1'b0);
      applyStimulus("post_rst1", 16'sd0, -16'sd8192, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
